// File: rtl/mmio_uart_tx_pkg.sv
// Shared state type, register offsets and bit positions for the MMIO UART transmitter.
package mmio_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic [3:0] UART_TXDATA_OFS = 4'h0;
  localparam logic [3:0] UART_STATUS_OFS = 4'h4;
  localparam logic [3:0] UART_CTRL_OFS   = 4'h8;
  localparam logic [3:0] UART_BAUD_OFS   = 4'hC;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_COUNT_LSB = 8;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;
  localparam int CTRL_ODD_BIT = 2;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push to a full FIFO is accepted when a pop
// happens on the same edge.
module sync_fifo #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DWIDTH-1:0]        wdata,
  input  logic                     pop,
  output logic [DWIDTH-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus, fed by a TX FIFO.
// Define MMIO_UART_TX_PARITY_EN to add a parity bit (even, or odd via CTRL[2]).
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_4000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic        dmem_wen,
  input  logic [3:0]  dmem_wr_mask,
  output logic [31:0] dmem_rdata,
  output logic        dmem_sel,
  output logic        uart_txd,
  output logic        tx_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [15:0] baud_q, baud_d;
  logic        txd_q, txd_d, busy_q, busy_d;
  logic        en_q, en_d, ovf_q, ovf_d, par_q, par_d;
  logic        odd_bit;

  logic [3:0]    reg_ofs;
  logic          wr_en, bit_done, start_frame;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          unused_bits;

  assign unused_bits = ^{dmem_addr[1:0], dmem_wdata[31:16], dmem_wr_mask[3:2]};

  assign dmem_sel  = (dmem_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_ofs   = {dmem_addr[3:2], 2'b00};
  assign wr_en     = dmem_sel && dmem_wen;
  assign fifo_push = wr_en && (reg_ofs == UART_TXDATA_OFS) && dmem_wr_mask[0];

  sync_fifo #(.DWIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (dmem_wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef MMIO_UART_TX_PARITY_EN
  logic odd_q, odd_d;
  assign odd_bit = odd_q;

  always_comb begin
    odd_d = odd_q;
    if (wr_en && (reg_ofs == UART_CTRL_OFS)) odd_d = dmem_wdata[CTRL_ODD_BIT];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) odd_q <= 1'b0;
    else     odd_q <= odd_d;
  end
`else
  assign odd_bit = 1'b0;
`endif

  always_comb begin
    en_d   = en_q;
    ovf_d  = ovf_q;
    baud_d = baud_q;
    if (wr_en) begin
      case (reg_ofs)
        UART_CTRL_OFS: begin
          en_d = dmem_wdata[CTRL_EN_BIT];
          if (dmem_wdata[CTRL_CLR_BIT]) ovf_d = 1'b0;
        end
        UART_BAUD_OFS: if (dmem_wr_mask[1:0] == 2'b11) baud_d = dmem_wdata[15:0];
        default: ;
      endcase
    end
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  // Every non-idle state shares the bit timer; a new frame starts from IDLE or straight
  // out of STOP so queued bytes go out without an idle gap.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    baud_cnt_d  = baud_cnt_q;
    txd_d       = txd_q;
    par_d       = par_q;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;
    bit_done    = (baud_cnt_q == 16'd0);
    if (state_q != IDLE) baud_cnt_d = bit_done ? baud_q : baud_cnt_q - 16'd1;
    case (state_q)
      IDLE:  start_frame = en_q && !fifo_empty;
      START: if (bit_done) begin
        txd_d     = shift_q[0];
        bit_idx_d = 3'd0;
        state_d   = DATA;
      end
      DATA: if (bit_done) begin
        if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
          txd_d   = par_q ^ odd_bit;
          state_d = PARITY;
`else
          txd_d   = 1'b1;
          state_d = STOP;
`endif
        end else begin
          shift_d   = shift_q >> 1;
          txd_d     = shift_q[1];
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      PARITY: if (bit_done) begin
        txd_d   = 1'b1;
        state_d = STOP;
      end
      STOP: if (bit_done) begin
        start_frame = en_q && !fifo_empty;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (start_frame) begin
      fifo_pop   = 1'b1;
      shift_d    = fifo_rdata;
      par_d      = ^fifo_rdata;
      txd_d      = 1'b0;
      baud_cnt_d = baud_q;
      state_d    = START;
    end
    busy_d = (state_d != IDLE) || fifo_push || !fifo_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      baud_cnt_q <= '0;
      baud_q     <= DIV_RESET;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      en_q       <= 1'b0;
      ovf_q      <= 1'b0;
      par_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      baud_q     <= baud_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      en_q       <= en_d;
      ovf_q      <= ovf_d;
      par_q      <= par_d;
    end
  end

  always_comb begin
    dmem_rdata = '0;
    if (dmem_sel) begin
      case (reg_ofs)
        UART_STATUS_OFS: begin
          dmem_rdata[STAT_FULL_BIT]  = fifo_full;
          dmem_rdata[STAT_EMPTY_BIT] = fifo_empty;
          dmem_rdata[STAT_BUSY_BIT]  = busy_q;
          dmem_rdata[STAT_OVF_BIT]   = ovf_q;
          dmem_rdata[STAT_COUNT_LSB +: 8] = 8'(fifo_count);
        end
        UART_CTRL_OFS: begin
          dmem_rdata[CTRL_EN_BIT]  = en_q;
          dmem_rdata[CTRL_ODD_BIT] = odd_bit;
        end
        UART_BAUD_OFS: dmem_rdata[15:0] = baud_q;
        default: ;
      endcase
    end
  end

  assign uart_txd = txd_q;
  assign tx_busy  = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register-access vector table, hand-written frame
// timing sequences, and randomized frame batches checked against a bit-level line model.
module tb_mmio_uart_tx;

`ifdef MMIO_UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic        dmem_wen = 1'b0;
  logic [3:0]  dmem_wr_mask = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_sel;
  logic        uart_txd;
  logic        tx_busy;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_uart_tx dut (
    .clk          (clk),
    .rst          (rst),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wen     (dmem_wen),
    .dmem_wr_mask (dmem_wr_mask),
    .dmem_rdata   (dmem_rdata),
    .dmem_sel     (dmem_sel),
    .uart_txd     (uart_txd),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          do_wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] raddr;
    logic [31:0] exp_rdata;
    logic        exp_sel;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  model_q[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus store: driven on the falling edge, captured on the next rising edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    @(negedge clk);
    dmem_addr    = addr;
    dmem_wdata   = data;
    dmem_wr_mask = mask;
    dmem_wen     = 1'b1;
    @(posedge clk);
    #1;
    dmem_wen = 1'b0;
  endtask

  task automatic readReg(input logic [31:0] addr, output logic [31:0] data, output logic sel);
    dmem_wen  = 1'b0;
    dmem_addr = addr;
    #1;
    data = dmem_rdata;
    sel  = dmem_sel;
  endtask

  function automatic logic [31:0] statusWord(input int count, input bit ovf, input bit busy);
    return (32'(count) << 8) | (32'(ovf) << 3) | (32'(busy) << 2) |
           (32'(count == 0) << 1) | 32'(count == 8);
  endfunction

  // Expects to be entered during the first clock of the start bit; returns during the
  // first clock after the stop bit.
  task automatic checkFrame(input logic [7:0] b, input int baud, input bit odd, input string tag);
    bit   exp_q[$];
    int   ones;
    bit   ok;
    logic got;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (PAR_BUILD) exp_q.push_back(bit'(ones % 2) ^ odd);
    exp_q.push_back(1'b1);
    foreach (exp_q[i]) begin
      ok  = 1'b1;
      got = exp_q[i];
      for (int k = 0; k <= baud; k++) begin
        if (ok && (uart_txd !== exp_q[i])) begin
          ok  = 1'b0;
          got = uart_txd;
        end
        @(posedge clk);
        #1;
      end
      checkOutput($sformatf("%s byte 0x%02h bit%0d", tag, b, i), 32'(got), 32'(exp_q[i]));
    end
  endtask

  task automatic drainModel(input int baud, input bit odd, input string tag);
    logic [7:0] b;
    while (model_q.size() > 0) begin
      b = model_q.pop_front();
      checkFrame(b, baud, odd, tag);
    end
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        sel;
    logic [7:0]  b;
    int          baud, n;
    bit          odd;

    vecs.push_back('{"reset status",   0, 0, 0, 0, 32'h4004, 32'h0000_0002, 1});
    vecs.push_back('{"txdata reads 0", 0, 0, 0, 0, 32'h4000, 32'h0, 1});
    vecs.push_back('{"reset ctrl",     0, 0, 0, 0, 32'h4008, 32'h0, 1});
    vecs.push_back('{"reset bauddiv",  0, 0, 0, 0, 32'h400C, 32'd15, 1});
    vecs.push_back('{"baud mask 0001", 1, 32'h400C, 32'hFFFF_0007, 4'b0001, 32'h400C, 32'd15, 1});
    vecs.push_back('{"baud mask 0011", 1, 32'h400C, 32'hABCD_0007, 4'b0011, 32'h400C, 32'd7, 1});
    vecs.push_back('{"baud addr[1:0]", 1, 32'h400E, 32'h0000_0003, 4'b1111, 32'h400C, 32'd3, 1});
    vecs.push_back('{"ctrl write 5",   1, 32'h4008, 32'h0000_0005, 4'b1111, 32'h4008,
                     PAR_BUILD ? 32'h5 : 32'h1, 1});
    vecs.push_back('{"ctrl write 0",   1, 32'h4008, 32'h0, 4'b1111, 32'h4008, 32'h0, 1});
    vecs.push_back('{"status ro",      1, 32'h4004, 32'hFFFF_FFFF, 4'b1111, 32'h4004, 32'h2, 1});
    vecs.push_back('{"txdata mask 1110", 1, 32'h4000, 32'h0000_00A5, 4'b1110, 32'h4004, 32'h2, 1});
    vecs.push_back('{"store off window", 1, 32'h5000, 32'h0000_0011, 4'b1111, 32'h4004, 32'h2, 1});
    vecs.push_back('{"read off window",  0, 0, 0, 0, 32'h5004, 32'h0, 0});
    vecs.push_back('{"read below window",0, 0, 0, 0, 32'h3FFC, 32'h0, 0});

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset txd", 32'(uart_txd), 32'd1);
    checkOutput("reset busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      if (vecs[i].do_wr) applyStimulus(vecs[i].waddr, vecs[i].wdata, vecs[i].wmask);
      readReg(vecs[i].raddr, rd, sel);
      checkOutput({vecs[i].name, " rdata"}, rd, vecs[i].exp_rdata);
      checkOutput({vecs[i].name, " sel"}, 32'(sel), 32'(vecs[i].exp_sel));
    end

    // Single 0x55 frame at 4 clocks per bit: start bit right after the edge following the store.
    $display("[TB] single frame 0x55");
    applyStimulus(32'h4008, 32'h1, 4'hF);
    applyStimulus(32'h4000, 32'h55, 4'hF);
    checkOutput("busy after store", 32'(tx_busy), 32'd1);
    @(posedge clk);
    #1;
    checkFrame(8'h55, 3, 1'b0, "frame55");
    checkOutput("busy after frame", 32'(tx_busy), 32'd0);
    checkOutput("idle line", 32'(uart_txd), 32'd1);

    // Overflow with EN off, then clear OVF and enable in one CTRL write.
    $display("[TB] overflow sequence");
    applyStimulus(32'h400C, 32'd1, 4'b0011);
    applyStimulus(32'h4008, 32'h0, 4'hF);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (model_q.size() < 8) model_q.push_back(b);
      applyStimulus(32'h4000, {24'h0, b}, 4'hF);
    end
    readReg(32'h4004, rd, sel);
    checkOutput("status overflow", rd, statusWord(8, 1'b1, 1'b1));
    applyStimulus(32'h4008, 32'h3, 4'hF);
    readReg(32'h4004, rd, sel);
    checkOutput("status ovf cleared", rd, statusWord(8, 1'b0, 1'b1));
    @(posedge clk);
    #1;
    drainModel(1, 1'b0, "b2b");
    readReg(32'h4004, rd, sel);
    checkOutput("status drained", rd, statusWord(0, 1'b0, 1'b0));

    // Push into a full FIFO on the very edge the first frame pops.
    $display("[TB] push and pop same edge");
    applyStimulus(32'h400C, 32'd0, 4'b0011);
    applyStimulus(32'h4008, 32'h0, 4'hF);
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      model_q.push_back(b);
      applyStimulus(32'h4000, {24'h0, b}, 4'hF);
    end
    applyStimulus(32'h4008, 32'h1, 4'hF);
    b = 8'($urandom);
    model_q.push_back(b);
    applyStimulus(32'h4000, {24'h0, b}, 4'hF);
    readReg(32'h4004, rd, sel);
    checkOutput("status push+pop full", rd, statusWord(8, 1'b0, 1'b1));
    drainModel(0, 1'b0, "pushpop");
    checkOutput("busy after pushpop", 32'(tx_busy), 32'd0);

    // Parity selection on 0x07 (three ones); without the feature both frames are plain 8N1.
    $display("[TB] parity frames");
    applyStimulus(32'h400C, 32'd1, 4'b0011);
    applyStimulus(32'h4008, 32'h1, 4'hF);
    applyStimulus(32'h4000, 32'h07, 4'hF);
    @(posedge clk);
    #1;
    checkFrame(8'h07, 1, 1'b0, "even");
    checkOutput("busy after even frame", 32'(tx_busy), 32'd0);
    applyStimulus(32'h4008, 32'h5, 4'hF);
    applyStimulus(32'h4000, 32'h07, 4'hF);
    @(posedge clk);
    #1;
    checkFrame(8'h07, 1, 1'b1, "odd");
    checkOutput("busy after odd frame", 32'(tx_busy), 32'd0);

    $display("[TB] randomized batches");
    for (int it = 0; it < 6; it++) begin
      baud = $urandom_range(0, 2);
      odd  = 1'($urandom_range(0, 1));
      n    = $urandom_range(1, 8);
      applyStimulus(32'h400C, 32'(baud), 4'b0011);
      applyStimulus(32'h4008, {29'h0, odd, 2'b00}, 4'hF);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        model_q.push_back(b);
        applyStimulus(32'h4000, {24'($urandom), b}, 4'hF);
      end
      readReg(32'h4004, rd, sel);
      checkOutput($sformatf("rnd%0d status", it), rd, statusWord(model_q.size(), 1'b0, 1'b1));
      applyStimulus(32'h4008, {29'h0, odd, 2'b01}, 4'hF);
      @(posedge clk);
      #1;
      drainModel(baud, odd, $sformatf("rnd%0d", it));
      checkOutput($sformatf("rnd%0d busy", it), 32'(tx_busy), 32'd0);
    end

    // Reset while data bit 3 of a 0x00 frame drives the line low.
    $display("[TB] reset mid frame");
    applyStimulus(32'h400C, 32'd3, 4'b0011);
    applyStimulus(32'h4008, 32'h1, 4'hF);
    applyStimulus(32'h4000, 32'h00, 4'hF);
    @(posedge clk);
    #1;
    repeat (17) begin
      @(posedge clk);
      #1;
    end
    checkOutput("line low before reset", 32'(uart_txd), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("txd on reset", 32'(uart_txd), 32'd1);
    checkOutput("busy on reset", 32'(tx_busy), 32'd0);
    readReg(32'h4004, rd, sel);
    checkOutput("status after reset", rd, 32'h0000_0002);
    readReg(32'h400C, rd, sel);
    checkOutput("bauddiv after reset", rd, 32'd15);
    readReg(32'h4008, rd, sel);
    checkOutput("ctrl after reset", rd, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (uart_txd !== 1'b1) sel = 1'b0;
    end
    checkOutput("line idle after reset", 32'(sel), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
